// File: rtl/mcp3008_accel_reader.sv
// ---------------------------------------------------------------------------
// mcp3008_accel_reader
// SPI master for the MCP3004/3008 10-bit ADC that samples the throttle pedal
// and turns the raw code into the accel command for the commutation/PWM stage.
//
// Frame: cs_n low, SETUP half-period, then 17 SCLK periods (high half, low
// half). The 5 command bits {start, sgl, ch[2:0]} go out on din, changing on
// sclk falling edges. dout is sampled on the clk edge that raises sclk:
// rise 7 carries the null bit, rises 8..17 carry B9..B0. After the low half of
// period 17, cs_n rises, data/accel update and valid pulses; a GAP of
// GAP_HALVES half-periods keeps cs_n high before the next frame.
//
// Handshake: in IDLE a frame is accepted on any clk edge where start=1
// (AUTO=0) or on every IDLE edge (AUTO=1). start is ignored while busy and is
// never queued. sgl/ch are captured only at acceptance. valid is a 1-clk
// pulse with data/accel already updated on that cycle.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           frame request pulse (AUTO=0 only)
//   sgl, ch[2:0]    mode and channel, captured at acceptance
//   dout            ADC serial data out
//   sclk, cs_n, din SPI pins towards the ADC
//   busy            high from acceptance through the end of the gap
//   valid           1-clk pulse when data/accel update
//   data[9:0]       last raw ADC code
//   accel[9:0]      dead-band/clamp mapped throttle 0..ACCEL_MAX
//   null_err        sticky null-bit error, cleared only by reset
//
// Parameter notes: SCLK_HALF >= 2, GAP_HALVES >= 1,
// (ACCEL_HI-ACCEL_LO)*2 == ACCEL_MAX.
// ---------------------------------------------------------------------------
module mcp3008_accel_reader #(
    parameter int SCLK_HALF  = 2700,
    parameter int GAP_HALVES = 2,
    parameter int AUTO       = 1,
    parameter int ACCEL_LO   = 280,
    parameter int ACCEL_HI   = 780,
    parameter int ACCEL_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sgl,
    input  logic [2:0] ch,
    input  logic       dout,
    output logic       sclk,
    output logic       cs_n,
    output logic       din,
    output logic       busy,
    output logic       valid,
    output logic [9:0] data,
    output logic [9:0] accel,
    output logic       null_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int DIV_W = $clog2(SCLK_HALF);
    localparam int GAP_W = $clog2(GAP_HALVES + 1);

    // Half-period index inside SHIFT: even = sclk high half of period
    // half_cnt/2+1, odd = its low half. 33 is the low half of period 17.
    localparam logic [5:0] HALF_NULL = 6'd11;  // ends before rise 7
    localparam logic [5:0] HALF_D9   = 6'd13;  // ends before rise 8
    localparam logic [5:0] HALF_LAST = 6'd33;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       half_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       cmd_sr;     // remaining command bits sgl, ch2, ch1, ch0
    logic [9:0]       shift_q;
    logic             tick;
    logic             accept;
    logic [10:0]      raw_ext;
    logic [10:0]      map_val;

    assign tick   = (div_cnt == DIV_W'(SCLK_HALF - 1));
    assign accept = (state == ST_IDLE) && ((AUTO != 0) || start);

    // Dead-band / clamp map, done in 11 bits so the subtraction cannot wrap.
    always_comb begin
        raw_ext = {1'b0, shift_q};
        map_val = '0;
        if (raw_ext <= 11'(ACCEL_LO)) begin
            map_val = '0;
        end else if (raw_ext >= 11'(ACCEL_HI)) begin
            map_val = 11'(ACCEL_MAX);
        end else begin
            map_val = (raw_ext - 11'(ACCEL_LO)) << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            cmd_sr   <= '0;
            shift_q  <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            din      <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            data     <= '0;
            accel    <= '0;
            null_err <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Divider is parked at 0 in IDLE so acceptance restarts it.
            if (state == ST_IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_SETUP;
                        busy   <= 1'b1;
                        cs_n   <= 1'b0;
                        din    <= 1'b1;
                        sclk   <= 1'b0;
                        cmd_sr <= {sgl, ch};
                    end
                end

                ST_SETUP: begin
                    if (tick) begin
                        state    <= ST_SHIFT;
                        sclk     <= 1'b1;
                        half_cnt <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (tick) begin
                        half_cnt <= half_cnt + 1'b1;
                        if (!half_cnt[0]) begin
                            // Falling edge: present the next command bit.
                            sclk   <= 1'b0;
                            din    <= cmd_sr[3];
                            cmd_sr <= {cmd_sr[2:0], 1'b0};
                        end else if (half_cnt == HALF_LAST) begin
                            cs_n    <= 1'b1;
                            data    <= shift_q;
                            accel   <= map_val[9:0];
                            valid   <= 1'b1;
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end else begin
                            // Rising edge: dout is sampled on this same clk edge.
                            sclk <= 1'b1;
                            if (half_cnt == HALF_NULL) begin
                                if (dout) begin
                                    null_err <= 1'b1;
                                end
                            end else if (half_cnt >= HALF_D9) begin
                                shift_q <= {shift_q[8:0], dout};
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_W'(GAP_HALVES - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp3008_accel_reader.sv
// ---------------------------------------------------------------------------
// Bench for mcp3008_accel_reader. Two instances share clock, reset, sgl, ch:
// u[0] has AUTO=0 (start-driven), u[1] has AUTO=1 (free-running). Each has
// an ADC pin model and a frame-timing model expressed as "cycles since
// acceptance" arithmetic; a negedge process compares every output each cycle.
// ---------------------------------------------------------------------------
module tb_mcp3008_accel_reader;

    localparam int H        = 2;
    localparam int G        = 2;
    localparam int DONE_N   = 35 * H;
    localparam int FRAME_N  = (35 + G) * H;
    localparam int NULL_N   = 13 * H;
    localparam int LO       = 280;
    localparam int HI       = 780;
    localparam int AMAX     = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_w = 2'b00;
    logic       sgl = 1'b0;
    logic [2:0] ch = 3'd0;

    int checks = 0;
    int errors = 0;

    // {null_bit, code} entries the u[0] ADC model serves before going random.
    logic [10:0] plan_q[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_fn(input int x);
        if (x <= LO) return 0;
        if (x >= HI) return AMAX;
        return (x - LO) * 2;
    endfunction

    // Bit the ADC presents for sclk rise r.
    function automatic logic adc_bit(input logic [10:0] f, input int r);
        if (r == 7) return f[10];
        if (r >= 8 && r <= 17) return f[17 - r];
        return 1'($urandom_range(0, 1));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_u
        logic       sclk, cs_n, din, busy, valid, null_err;
        logic [9:0] data, accel;
        logic       dout = 1'b0;

        mcp3008_accel_reader #(
            .SCLK_HALF (H),
            .GAP_HALVES(G),
            .AUTO      (g),
            .ACCEL_LO  (LO),
            .ACCEL_HI  (HI),
            .ACCEL_MAX (AMAX)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_w[g]),
            .sgl     (sgl),
            .ch      (ch),
            .dout    (dout),
            .sclk    (sclk),
            .cs_n    (cs_n),
            .din     (din),
            .busy    (busy),
            .valid   (valid),
            .data    (data),
            .accel   (accel),
            .null_err(null_err)
        );

        // ADC pin model
        logic [10:0] cur = '0;
        int          rises = 0;
        logic [5:1]  din_log = '0;
        logic [10:0] exp_q[$];

        always @(negedge cs_n) begin
            if (g == 0 && plan_q.size() > 0) cur = plan_q.pop_front();
            else cur = {1'b0, 10'($urandom_range(0, 1023))};
            exp_q.push_back(cur);
            rises = 0;
            dout = 1'($urandom_range(0, 1));
        end

        always @(posedge sclk) begin
            if (!cs_n) begin
                rises++;
                if (rises <= 5) din_log[rises] = din;
            end
        end

        always @(negedge sclk) begin
            if (!cs_n) dout = adc_bit(cur, rises + 1);
        end

        // Frame model: m_n = clk edges since the accepting edge.
        bit          m_active = 1'b0;
        int          m_n = 0;
        bit          m_null = 1'b0;
        int          m_data = 0;
        int          m_accel = 0;
        logic [4:0]  m_cmd = '0;
        logic [10:0] f;

        always @(posedge clk) begin
            if (!rst_n) begin
                m_active = 1'b0;
                m_n = 0;
                m_null = 1'b0;
                m_data = 0;
                m_accel = 0;
                exp_q.delete();
            end else if (m_active) begin
                m_n++;
                if (m_n == NULL_N && exp_q.size() > 0 && exp_q[0][10]) m_null = 1'b1;
                if (m_n == DONE_N) begin
                    check($sformatf("u%0d_frame_queued", g), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        f = exp_q.pop_front();
                        m_data = int'(f[9:0]);
                        m_accel = map_fn(int'(f[9:0]));
                    end
                end
                if (m_n == FRAME_N) m_active = 1'b0;
            end else if (g == 1 || start_w[g]) begin
                m_active = 1'b1;
                m_n = 0;
                m_cmd = {1'b1, sgl, ch};
            end
        end

        int k;
        bit e_cs, e_sclk, e_din, e_valid;

        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("u%0d_rst_cs_n", g), cs_n, 1);
                check($sformatf("u%0d_rst_sclk", g), sclk, 0);
                check($sformatf("u%0d_rst_din", g), din, 0);
                check($sformatf("u%0d_rst_busy", g), busy, 0);
                check($sformatf("u%0d_rst_valid", g), valid, 0);
                check($sformatf("u%0d_rst_data", g), data, 0);
                check($sformatf("u%0d_rst_accel", g), accel, 0);
                check($sformatf("u%0d_rst_null", g), null_err, 0);
            end else begin
                k = m_n / (2 * H) + 1;
                e_cs = !(m_active && m_n < DONE_N);
                e_sclk = m_active && m_n < 34 * H && ((m_n / H) % 2 == 1);
                e_din = m_active && k <= 5 && m_cmd[5 - k];
                e_valid = m_active && m_n == DONE_N;
                check($sformatf("u%0d_cs_n", g), cs_n, e_cs);
                check($sformatf("u%0d_sclk", g), sclk, e_sclk);
                check($sformatf("u%0d_din", g), din, e_din);
                check($sformatf("u%0d_busy", g), busy, m_active);
                check($sformatf("u%0d_valid", g), valid, e_valid);
                check($sformatf("u%0d_data", g), data, m_data);
                check($sformatf("u%0d_accel", g), accel, m_accel);
                check($sformatf("u%0d_null_err", g), null_err, m_null);
                if (e_valid) check($sformatf("u%0d_rises", g), rises, 17);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (g_u[0].busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", n < 200, 1);
    endtask

    // Leaves the caller #1 after the accepting edge.
    task automatic pulse_start0();
        @(posedge clk); #1 start_w[0] = 1'b1;
        @(posedge clk); #1 start_w[0] = 1'b0;
    endtask

    task automatic wait_valid0(input bit noise, output int cnt);
        bit got = 1'b0;
        cnt = 0;
        while (!got && cnt < 300) begin
            if (noise) begin
                start_w[0] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    sgl = 1'($urandom_range(0, 1));
                    ch = 3'($urandom_range(0, 7));
                end
            end
            @(posedge clk); #1;
            cnt++;
            if (g_u[0].valid === 1'b1) got = 1'b1;
        end
        start_w[0] = 1'b0;
        check("valid_timeout", got, 1);
    endtask

    task automatic frame0(input logic [10:0] entry, input bit noise, output int cnt);
        wait_idle0();
        plan_q.push_back(entry);
        pulse_start0();
        wait_valid0(noise, cnt);
    endtask

    // ---------------- main sequence ----------------
    int codes[5] = '{1023, 0, 512, 780, 281};
    int accs[5]  = '{1000, 0, 464, 1000, 2};

    initial begin
        int cnt, n, cs_low, vcount;
        bit got;

        // 1: reset values, then idle with AUTO=0 and no start
        repeat (4) @(negedge clk);
        check("t1_rst_cs_n", g_u[0].cs_n, 1);
        check("t1_rst_data", g_u[0].data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cs_low = 0;
        repeat (1000) begin
            @(negedge clk);
            if (g_u[0].cs_n !== 1'b1) cs_low++;
        end
        check("t1_idle_cs_low", cs_low, 0);

        // 2: command bits, sclk count, latency
        sgl = 1'b1; ch = 3'b101;
        frame0({1'b0, 10'd600}, 1'b0, cnt);
        check("t2_latency", cnt, 70);
        check("t2_din1", g_u[0].din_log[1], 1);
        check("t2_din2", g_u[0].din_log[2], 1);
        check("t2_din3", g_u[0].din_log[3], 1);
        check("t2_din4", g_u[0].din_log[4], 0);
        check("t2_din5", g_u[0].din_log[5], 1);
        check("t2_rises", g_u[0].rises, 17);
        check("t2_data", g_u[0].data, 600);
        check("t2_accel", g_u[0].accel, 640);

        // 3: mapping boundaries
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_model_map%0d", i), map_fn(codes[i]), accs[i]);
            frame0({1'b0, 10'(codes[i])}, 1'b1, cnt);
            check($sformatf("t3_data%0d", i), g_u[0].data, codes[i]);
            check($sformatf("t3_accel%0d", i), g_u[0].accel, accs[i]);
        end

        // 4: sticky null error
        check("t4_null_before", g_u[0].null_err, 0);
        frame0({1'b1, 10'd500}, 1'b1, cnt);
        check("t4_null_set", g_u[0].null_err, 1);
        check("t4_null_data", g_u[0].data, 500);
        for (int i = 0; i < 2; i++) begin
            frame0({1'b0, 10'(300 + i)}, 1'b1, cnt);
            check($sformatf("t4_null_sticky%0d", i), g_u[0].null_err, 1);
        end

        // random frames with start/ch/sgl noise during busy
        for (int i = 0; i < 8; i++) begin
            sgl = 1'($urandom_range(0, 1));
            ch = 3'($urandom_range(0, 7));
            frame0({1'b0, 10'($urandom_range(0, 1023))}, 1'b1, cnt);
            check($sformatf("rnd_latency%0d", i), cnt, 70);
        end

        // 5: free-running period on the AUTO instance, start noise ignored
        wait_idle0();
        for (int i = 0; i < 5; i++) begin
            n = 0; got = 1'b0;
            while (!got && n < 200) begin
                start_w[1] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
                if (g_u[1].valid === 1'b1) got = 1'b1;
            end
            check("t5_valid_timeout", got, 1);
            if (i > 0) check($sformatf("t5_period%0d", i), n, 75);
        end
        start_w[1] = 1'b0;

        // 6: abort at sclk rise 10
        do_reset();
        check("t6_null_cleared", g_u[0].null_err, 0);
        sgl = 1'b0; ch = 3'd2;
        wait_idle0();
        plan_q.push_back({1'b0, 10'd900});
        pulse_start0();
        n = 0;
        while (g_u[0].rises != 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reach_rise10", g_u[0].rises, 10);
        rst_n = 1'b0;
        #1;
        check("t6_abort_cs_n", g_u[0].cs_n, 1);
        check("t6_abort_sclk", g_u[0].sclk, 0);
        check("t6_abort_valid", g_u[0].valid, 0);
        check("t6_abort_data", g_u[0].data, 0);
        plan_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        vcount = 0;
        repeat (150) begin
            @(negedge clk);
            if (g_u[0].valid === 1'b1) vcount++;
        end
        check("t6_no_valid", vcount, 0);
        check("t6_data_kept", g_u[0].data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
